// File: rtl/stopwatch_ssd_ctrl.sv
// MM:SS stopwatch with start/pause/clear control, driving a four-digit
// common-anode 7-segment display scanned by the divider's select lines.
module stopwatch_ssd_ctrl #(
    parameter int unsigned SCAN_W   = 2,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned MAX_TENS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_1hz,
    input  logic [SCAN_W-1:0] clk_ctl,
    input  logic              start_pb,
    input  logic              clr,
    output logic              running,
    output logic              wrap,
    output logic [DIGITS-1:0] ssd_ctl,
    output logic [7:0]        ssd_out
);

    localparam logic [3:0] MaxTens = 4'(MAX_TENS);
    localparam logic [3:0] MaxOnes = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    state_e state_q, state_d;

    logic clk_1hz_q;
    logic start_pb_q;
    logic tick;
    logic press;
    logic count_en;

    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;

    logic wrap_q, wrap_d;
    logic running_q;

    logic [DIGITS-1:0] ssd_ctl_q, ssd_ctl_d;
    logic [7:0]        ssd_out_q, ssd_out_d;
    logic [3:0]        digit_sel;
    logic              dp_sel;

    assign tick     = clk_1hz & ~clk_1hz_q;
    assign press    = start_pb & ~start_pb_q;
    assign count_en = (state_q == StRun) & tick & ~clr;

    // Next state: clear wins over everything; a PAUSE->RUN press swallows a same-cycle tick
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StIdle;
        end else if (press) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // BCD carry chain through ss then mm
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clr) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (count_en) begin
            if (sec_ones_q != MaxOnes) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != MaxTens) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q != MaxOnes) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q != MaxTens) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            wrap_d     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Digit select; the decimal point marks the MM.SS separator on min_ones
    always_comb begin
        digit_sel = sec_ones_q;
        ssd_ctl_d = 4'b1110;
        dp_sel    = 1'b1;
        case (clk_ctl)
            SCAN_W'(0): begin
                digit_sel = sec_ones_q;
                ssd_ctl_d = 4'b1110;
            end
            SCAN_W'(1): begin
                digit_sel = sec_tens_q;
                ssd_ctl_d = 4'b1101;
            end
            SCAN_W'(2): begin
                digit_sel = min_ones_q;
                ssd_ctl_d = 4'b1011;
                dp_sel    = 1'b0;
            end
            SCAN_W'(3): begin
                digit_sel = min_tens_q;
                ssd_ctl_d = 4'b0111;
            end
            default: begin
                digit_sel = sec_ones_q;
                ssd_ctl_d = 4'b1110;
            end
        endcase
        ssd_out_d = {seg7(digit_sel), dp_sel};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StIdle;
            clk_1hz_q  <= 1'b0;
            start_pb_q <= 1'b0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            wrap_q     <= 1'b0;
            running_q  <= 1'b0;
            ssd_ctl_q  <= 4'b1111;
            ssd_out_q  <= 8'hFF;
        end else begin
            state_q    <= state_d;
            clk_1hz_q  <= clk_1hz;
            start_pb_q <= start_pb;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            wrap_q     <= wrap_d;
            // Tracks the state register exactly, no extra cycle of lag
            running_q  <= (state_d == StRun);
            ssd_ctl_q  <= ssd_ctl_d;
            ssd_out_q  <= ssd_out_d;
        end
    end

    assign running = running_q;
    assign wrap    = wrap_q;
    assign ssd_ctl = ssd_ctl_q;
    assign ssd_out = ssd_out_q;

endmodule

// File: tb/tb_stopwatch_ssd_ctrl.sv
// Directed bench for stopwatch_ssd_ctrl: display vector table plus hand-written
// sequences for wrap, held button, priority and asynchronous reset.
module tb_stopwatch_ssd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_1hz;
    logic [1:0] clk_ctl;
    logic       start_pb;
    logic       clr;
    logic       running;
    logic       wrap;
    logic [3:0] ssd_ctl;
    logic [7:0] ssd_out;

    int n_cmp = 0;
    int n_bad = 0;
    int wrap_cnt = 0;

    stopwatch_ssd_ctrl #(
        .SCAN_W  (2),
        .DIGITS  (4),
        .MAX_TENS(5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_1hz (clk_1hz),
        .clk_ctl (clk_ctl),
        .start_pb(start_pb),
        .clr     (clr),
        .running (running),
        .wrap    (wrap),
        .ssd_ctl (ssd_ctl),
        .ssd_out (ssd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ticks;
        logic [1:0] ctl;
        logic [3:0] exp_ctl;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick_pulse();
        clk_1hz = 1'b1;
        step();
        if (wrap) wrap_cnt++;
        clk_1hz = 1'b0;
        step();
        if (wrap) wrap_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_pulse();
    endtask

    task automatic press_pb();
        start_pb = 1'b1;
        step();
        start_pb = 1'b0;
        step();
    endtask

    task automatic show(input logic [1:0] ctl, input string name,
                        input logic [3:0] e_ctl, input logic [7:0] e_out);
        clk_ctl = ctl;
        step();
        step();
        chk({name, ".ctl"}, {28'd0, ssd_ctl}, {28'd0, e_ctl});
        chk({name, ".seg"}, {24'd0, ssd_out}, {24'd0, e_out});
    endtask

    initial begin
        int rises;
        logic prev;

        // Display table, applied from 00:12 in RUN
        vecs[0]  = '{0,   2'd0, 4'b1110, 8'b0010_0101};  // 00:12 '2'
        vecs[1]  = '{0,   2'd1, 4'b1101, 8'b1001_1111};  // '1'
        vecs[2]  = '{0,   2'd2, 4'b1011, 8'b0000_0010};  // '0' with dp
        vecs[3]  = '{0,   2'd3, 4'b0111, 8'b0000_0011};  // '0'
        vecs[4]  = '{3,   2'd0, 4'b1110, 8'b0100_1001};  // 00:15 '5'
        vecs[5]  = '{45,  2'd2, 4'b1011, 8'b1001_1110};  // 01:00 '1' dp
        vecs[6]  = '{0,   2'd0, 4'b1110, 8'b0000_0011};
        vecs[7]  = '{0,   2'd1, 4'b1101, 8'b0000_0011};
        vecs[8]  = '{36,  2'd0, 4'b1110, 8'b0100_0001};  // 01:36 '6'
        vecs[9]  = '{0,   2'd1, 4'b1101, 8'b0000_1101};  // '3'
        vecs[10] = '{1,   2'd0, 4'b1110, 8'b0001_1111};  // 01:37 '7'
        vecs[11] = '{1,   2'd0, 4'b1110, 8'b0000_0001};  // 01:38 '8'
        vecs[12] = '{1,   2'd0, 4'b1110, 8'b0000_1001};  // 01:39 '9'
        vecs[13] = '{565, 2'd3, 4'b0111, 8'b1001_1111};  // 11:04 '1'
        vecs[14] = '{0,   2'd2, 4'b1011, 8'b1001_1110};  // '1' dp
        vecs[15] = '{0,   2'd0, 4'b1110, 8'b1001_1001};  // '4'
        vecs[16] = '{0,   2'd1, 4'b1101, 8'b0000_0011};  // '0'

        rst_n = 1'b1; clk_1hz = 1'b0; clk_ctl = 2'd0; start_pb = 1'b0; clr = 1'b0;
        step();
        step();
        chk("rst.ctl", {28'd0, ssd_ctl}, 32'hF);
        chk("rst.seg", {24'd0, ssd_out}, 32'hFF);
        chk("rst.running", {31'd0, running}, 32'd0);
        chk("rst.wrap", {31'd0, wrap}, 32'd0);

        rst_n = 1'b0;
        step();
        step();
        chk("idle.ctl", {28'd0, ssd_ctl}, 32'hE);
        chk("idle.seg", {24'd0, ssd_out}, 32'h03);
        chk("idle.running", {31'd0, running}, 32'd0);

        press_pb();
        chk("start.running", {31'd0, running}, 32'd1);
        ticks(12);
        clk_ctl = 2'd1;
        step();
        chk("lat.ctl", {28'd0, ssd_ctl}, 32'hD);
        chk("lat.seg", {24'd0, ssd_out}, 32'h9F);

        for (int i = 0; i < 17; i++) begin
            ticks(vecs[i].ticks);
            clk_ctl = vecs[i].ctl;
            step();
            step();
            chk($sformatf("vec%0d.ctl", i), {28'd0, ssd_ctl}, {28'd0, vecs[i].exp_ctl});
            chk($sformatf("vec%0d.seg", i), {24'd0, ssd_out}, {24'd0, vecs[i].exp_out});
        end

        // 11:04 -> 59:58 is 2934 seconds
        ticks(2934);
        show(2'd3, "5958.mt", 4'b0111, 8'b0100_1001);
        show(2'd0, "5958.so", 4'b1110, 8'b0000_0001);
        tick_pulse();
        show(2'd1, "5959.st", 4'b1101, 8'b0100_1001);
        chk("wrap.early", wrap_cnt, 32'd0);
        clk_1hz = 1'b1;
        step();
        chk("wrap.pulse", {31'd0, wrap}, 32'd1);
        chk("wrap.running", {31'd0, running}, 32'd1);
        clk_1hz = 1'b0;
        step();
        chk("wrap.fall", {31'd0, wrap}, 32'd0);
        show(2'd3, "0000.mt", 4'b0111, 8'b0000_0011);
        show(2'd1, "0000.st", 4'b1101, 8'b0000_0011);

        // Held button from IDLE
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("clr.running", {31'd0, running}, 32'd0);
        rises = 0;
        prev = running;
        for (int i = 0; i < 1000; i++) begin
            start_pb = 1'b1;
            step();
            if (running && !prev) rises++;
            if (!running && prev) rises += 100;
            prev = running;
        end
        chk("hold.rises", rises, 32'd1);
        chk("hold.running", {31'd0, running}, 32'd1);
        start_pb = 1'b0;
        step();
        ticks(3);
        press_pb();
        chk("pause.running", {31'd0, running}, 32'd0);
        ticks(5);
        show(2'd0, "pause.so", 4'b1110, 8'b0000_1101);

        // PAUSE: tick and press together resume without counting
        clk_1hz = 1'b1; start_pb = 1'b1;
        step();
        clk_1hz = 1'b0; start_pb = 1'b0;
        step();
        chk("resume.running", {31'd0, running}, 32'd1);
        show(2'd0, "resume.so", 4'b1110, 8'b0000_1101);

        // RUN: tick and press together count then pause
        clk_1hz = 1'b1; start_pb = 1'b1;
        step();
        chk("runpress.running", {31'd0, running}, 32'd0);
        clk_1hz = 1'b0; start_pb = 1'b0;
        step();
        show(2'd0, "runpress.so", 4'b1110, 8'b1001_1001);

        // clr beats tick and press in RUN
        press_pb();
        chk("rerun.running", {31'd0, running}, 32'd1);
        wrap_cnt = 0;
        clk_1hz = 1'b1; start_pb = 1'b1; clr = 1'b1;
        step();
        chk("prio.running", {31'd0, running}, 32'd0);
        chk("prio.wrap", {31'd0, wrap}, 32'd0);
        clk_1hz = 1'b0; start_pb = 1'b0; clr = 1'b0;
        step();
        show(2'd0, "prio.so", 4'b1110, 8'b0000_0011);
        ticks(2);
        show(2'd0, "prio.idle", 4'b1110, 8'b0000_0011);

        // Async reset in RUN at 03:27 (207 seconds)
        press_pb();
        ticks(207);
        show(2'd0, "0327.so", 4'b1110, 8'b0001_1111);
        show(2'd2, "0327.mo", 4'b1011, 8'b0000_1100);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst.ctl", {28'd0, ssd_ctl}, 32'hF);
        chk("arst.seg", {24'd0, ssd_out}, 32'hFF);
        chk("arst.running", {31'd0, running}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        step();
        ticks(3);
        chk("post.running", {31'd0, running}, 32'd0);
        show(2'd2, "post.mo", 4'b1011, 8'b0000_0010);
        show(2'd0, "post.so", 4'b1110, 8'b0000_0011);
        press_pb();
        tick_pulse();
        chk("post.run", {31'd0, running}, 32'd1);
        show(2'd0, "post.so1", 4'b1110, 8'b1001_1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
